// File: rtl/structs.sv
// Shared definitions for the instruction cache: address split,
// partial-fetch codes and the L2 line-fill request bundle.
package structs;

  localparam int OFF_W   = 5;
  localparam int IDX_W   = 5;
  localparam int TAG_LSB = OFF_W + IDX_W;
  localparam int ADDR_W  = 32;

  localparam logic [1:0] PT_NONE  = 2'd0;
  localparam logic [1:0] PT_ONE   = 2'd1;
  localparam logic [1:0] PT_TWO   = 2'd2;
  localparam logic [1:0] PT_THREE = 2'd3;

  typedef struct packed {
    logic                    valid;
    logic [ADDR_W-OFF_W-1:0] line;
  } l2_req_t;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays,
// async read, single write port and flush-all.
module icache_line_store
  import structs::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int BLOCK_WIDTH = 256,
  parameter int ENTRIES     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [IDX_W-1:0]            rd_index,
  output logic                        rd_valid,
  output logic [ADDR_BITS-TAG_LSB-1:0] rd_tag,
  output logic [BLOCK_WIDTH-1:0]      rd_data,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_index,
  input  logic [ADDR_BITS-TAG_LSB-1:0] wr_tag,
  input  logic [BLOCK_WIDTH-1:0]      wr_data
);

  localparam int TAG_W = ADDR_BITS - TAG_LSB;

  logic [ENTRIES-1:0]     valid_q;
  logic [ENTRIES-1:0]     valid_d;
  logic [TAG_W-1:0]       tag_mem  [ENTRIES];
  logic [BLOCK_WIDTH-1:0] data_mem [ENTRIES];

  // Flush is applied last so it beats a same-cycle fill.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with zero-latency lookup,
// partial fetch at line end and a single outstanding L2 fill.
module instr_cache
  import structs::*;
#(
  parameter int ADDR_BITS   = 32,
  parameter int FETCH_WIDTH = 64,
  parameter int BLOCK_WIDTH = 256,
  parameter int ENTRIES     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_BITS-1:0]   current_pc,
  output logic                   hit_cache,
  output logic                   miss,
  output logic                   partial_access,
  output logic [1:0]             partial_type,
  output logic [FETCH_WIDTH-1:0] fetched_data,
  output logic                   read_l2_valid,
  output logic [ADDR_BITS-1:0]   read_addr_l2,
  input  logic                   ready_l2,
  input  logic                   update_l2_valid,
  input  logic [BLOCK_WIDTH-1:0] update_data_l2,
  input  logic                   flush
);

  localparam int TAG_W = ADDR_BITS - TAG_LSB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e  state_q;
  state_e  state_d;
  l2_req_t req_q;
  l2_req_t req_d;

  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [BLOCK_WIDTH-1:0] rd_data;
  logic [OFF_W-1:0]       offset;
  logic                   lookup_hit;
  logic                   wr_en;

  assign offset = current_pc[OFF_W-1:0];

  icache_line_store #(
    .ADDR_BITS  (ADDR_BITS),
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .ENTRIES    (ENTRIES)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .rd_index(current_pc[TAG_LSB-1:OFF_W]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(req_q.line[IDX_W-1:0]),
    .wr_tag  (req_q.line[ADDR_BITS-OFF_W-1:IDX_W]),
    .wr_data (update_data_l2)
  );

  always_comb begin
    lookup_hit = rd_valid
               && (rd_tag == current_pc[ADDR_BITS-1:TAG_LSB])
               && (state_q == S_IDLE);
    hit_cache      = lookup_hit;
    miss           = !lookup_hit;
    partial_access = 1'b0;
    partial_type   = PT_NONE;
    fetched_data   = '0;
    if (lookup_hit) begin
      // Shifting zero-fills bytes past the line end.
      fetched_data = FETCH_WIDTH'(rd_data >> {offset, 3'b000});
      case (offset)
        5'd26:   partial_type = PT_THREE;
        5'd28:   partial_type = PT_TWO;
        5'd30:   partial_type = PT_ONE;
        default: partial_type = PT_NONE;
      endcase
      partial_access = (partial_type != PT_NONE);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!lookup_hit) begin
          state_d    = S_REQ;
          req_d.valid = 1'b1;
          req_d.line  = current_pc[ADDR_BITS-1:OFF_W];
        end
      end
      S_REQ: begin
        if (req_q.valid && ready_l2) begin
          state_d     = S_WAIT;
          req_d.valid = 1'b0;
        end
      end
      S_WAIT: begin
        if (update_l2_valid) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign read_l2_valid = req_q.valid;
  assign read_addr_l2  = {req_q.line, {OFF_W{1'b0}}};

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: fills, partial fetches,
// conflicts, flush and reset during an outstanding fill.
module tb_instr_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  current_pc;
  logic         hit_cache;
  logic         miss;
  logic         partial_access;
  logic [1:0]   partial_type;
  logic [63:0]  fetched_data;
  logic         read_l2_valid;
  logic [31:0]  read_addr_l2;
  logic         ready_l2;
  logic         update_l2_valid;
  logic [255:0] update_data_l2;
  logic         flush;

  int checks = 0;
  int errors = 0;

  logic [255:0] line_a;
  logic [255:0] line_b;

  always #5 clk = ~clk;

  instr_cache dut (
    .clk            (clk),
    .rst            (rst),
    .current_pc     (current_pc),
    .hit_cache      (hit_cache),
    .miss           (miss),
    .partial_access (partial_access),
    .partial_type   (partial_type),
    .fetched_data   (fetched_data),
    .read_l2_valid  (read_l2_valid),
    .read_addr_l2   (read_addr_l2),
    .ready_l2       (ready_l2),
    .update_l2_valid(update_l2_valid),
    .update_data_l2 (update_data_l2),
    .flush          (flush)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [7:0] base);
    logic [255:0] l;
    for (int i = 0; i < 32; i++) begin
      l[8*i +: 8] = base + 8'(i);
    end
    return l;
  endfunction

  task automatic fill(input logic [31:0] pc,
                      input logic [255:0] line);
    current_pc = pc;
    #1;
    for (int n = 0; n < 8 && !read_l2_valid; n++) begin
      step();
    end
    check("fill_req", 64'(read_l2_valid), 64'd1);
    check("fill_addr", 64'(read_addr_l2),
          64'({pc[31:5], 5'b0}));
    ready_l2 = 1'b1;
    step();
    ready_l2 = 1'b0;
    step();
    update_data_l2  = line;
    update_l2_valid = 1'b1;
    step();
    update_l2_valid = 1'b0;
    #1;
  endtask

  initial begin
    line_a          = mk_line(8'hA0);
    line_b          = mk_line(8'h40);
    rst             = 1'b1;
    current_pc      = 32'h100;
    ready_l2        = 1'b0;
    update_l2_valid = 1'b0;
    update_data_l2  = '0;
    flush           = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_hit", 64'(hit_cache), 64'd0);
    check("rst_miss", 64'(miss), 64'd1);
    check("rst_part", 64'(partial_access), 64'd0);
    check("rst_ptype", 64'(partial_type), 64'd0);
    check("rst_data", fetched_data, 64'd0);
    check("rst_rdv", 64'(read_l2_valid), 64'd0);
    check("rst_raddr", 64'(read_addr_l2), 64'd0);

    // Cold miss with slow L2 handshake
    step();
    check("cold_rdv", 64'(read_l2_valid), 64'd1);
    check("cold_addr", 64'(read_addr_l2), 64'h100);
    check("cold_miss", 64'(miss), 64'd1);
    step();
    check("hold_rdv", 64'(read_l2_valid), 64'd1);
    check("hold_addr", 64'(read_addr_l2), 64'h100);
    ready_l2 = 1'b1;
    step();
    ready_l2 = 1'b0;
    #1;
    check("wait_rdv", 64'(read_l2_valid), 64'd0);
    check("wait_miss", 64'(miss), 64'd1);
    step();
    step();
    update_data_l2  = line_a;
    update_l2_valid = 1'b1;
    step();
    update_l2_valid = 1'b0;
    #1;
    check("fill_hit", 64'(hit_cache), 64'd1);
    check("fill_nomiss", 64'(miss), 64'd0);
    check("fill_part", 64'(partial_access), 64'd0);
    check("fill_data", fetched_data, 64'hA7A6A5A4A3A2A1A0);

    // Full and partial fetches near the line end
    current_pc = 32'h118;
    #1;
    check("h118_part", 64'(partial_access), 64'd0);
    check("h118_data", fetched_data, 64'hBFBEBDBCBBBAB9B8);
    current_pc = 32'h11E;
    #1;
    check("h11e_hit", 64'(hit_cache), 64'd1);
    check("h11e_part", 64'(partial_access), 64'd1);
    check("h11e_ptype", 64'(partial_type), 64'd1);
    check("h11e_data", fetched_data, 64'h000000000000BFBE);
    current_pc = 32'h11C;
    #1;
    check("h11c_ptype", 64'(partial_type), 64'd2);
    check("h11c_data", fetched_data, 64'h00000000BFBEBDBC);
    current_pc = 32'h11A;
    #1;
    check("h11a_ptype", 64'(partial_type), 64'd3);
    check("h11a_data", fetched_data, 64'h0000BFBEBDBCBBBA);
    current_pc = 32'h104;
    #1;
    check("h104_data", fetched_data, 64'hABAAA9A8A7A6A5A4);

    // Conflict on index 8
    current_pc = 32'h500;
    #1;
    check("c500_miss", 64'(miss), 64'd1);
    check("c500_hit", 64'(hit_cache), 64'd0);
    fill(32'h500, line_b);
    check("c500_fhit", 64'(hit_cache), 64'd1);
    check("c500_data", fetched_data, 64'h4746454443424140);
    current_pc = 32'h100;
    #1;
    check("c100_miss", 64'(miss), 64'd1);
    fill(32'h100, line_a);
    check("c100_hit", 64'(hit_cache), 64'd1);

    // Flush while hitting: this cycle unaffected
    flush = 1'b1;
    #1;
    check("fl_hit", 64'(hit_cache), 64'd1);
    check("fl_data", fetched_data, 64'hA7A6A5A4A3A2A1A0);
    step();
    flush = 1'b0;
    #1;
    check("fl_miss", 64'(miss), 64'd1);
    check("fl_hit2", 64'(hit_cache), 64'd0);

    // Flush racing the fill return
    step();
    check("fw_rdv", 64'(read_l2_valid), 64'd1);
    ready_l2 = 1'b1;
    step();
    ready_l2 = 1'b0;
    step();
    update_data_l2  = line_a;
    update_l2_valid = 1'b1;
    flush           = 1'b1;
    step();
    update_l2_valid = 1'b0;
    flush           = 1'b0;
    #1;
    check("fw_idle_rdv", 64'(read_l2_valid), 64'd0);
    check("fw_miss", 64'(miss), 64'd1);
    check("fw_hit", 64'(hit_cache), 64'd0);
    step();
    check("fw_rereq", 64'(read_l2_valid), 64'd1);

    // Reset while waiting on L2, late fill ignored
    ready_l2 = 1'b1;
    step();
    ready_l2 = 1'b0;
    #1;
    check("rw_wait", 64'(read_l2_valid), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rw_rdv", 64'(read_l2_valid), 64'd0);
    check("rw_raddr", 64'(read_addr_l2), 64'd0);
    check("rw_miss", 64'(miss), 64'd1);
    update_data_l2  = line_a;
    update_l2_valid = 1'b1;
    step();
    update_l2_valid = 1'b0;
    #1;
    check("rw_nohit", 64'(hit_cache), 64'd0);
    check("rw_miss2", 64'(miss), 64'd1);
    check("rw_data", fetched_data, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
